// File: rtl/plic_pkg.sv
// Shared constants and FSM state type for the PLIC target-context scheduler.
package plic_pkg;

    localparam int IRQ_NUM    = 32;
    localparam int PRIO_WIDTH = 3;
    localparam int ID_WIDTH   = $clog2(IRQ_NUM);

    typedef enum logic {
        SCAN  = 1'b0,
        CLAIM = 1'b1
    } state_e;

endpackage

// File: rtl/plic_prio_cmp.sv
// One step of the priority sweep: a qualified candidate replaces the running best
// only when strictly higher, so the lowest ID wins ties.
module plic_prio_cmp #(
    parameter int ID_WIDTH   = 5,
    parameter int PRIO_WIDTH = 3
) (
    input  logic                  cand_valid,
    input  logic [ID_WIDTH-1:0]   cand_id,
    input  logic [PRIO_WIDTH-1:0] cand_prio,
    input  logic [ID_WIDTH-1:0]   best_id,
    input  logic [PRIO_WIDTH-1:0] best_prio,
    output logic [ID_WIDTH-1:0]   new_id,
    output logic [PRIO_WIDTH-1:0] new_prio
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        new_id   = best_id;
        new_prio = best_prio;
        if (cand_valid && (cand_prio > best_prio)) begin
            new_id   = cand_id;
            new_prio = cand_prio;
        end
    end

endmodule

// File: rtl/plic_prio_scan.sv
// Serial PLIC priority scheduler: sweeps sources 1..IRQ_NUM-1 one per clock,
// publishes the best pending+enabled source and sequences the claim handshake.
module plic_prio_scan #(
    parameter int IRQ_NUM    = plic_pkg::IRQ_NUM,
    parameter int PRIO_WIDTH = plic_pkg::PRIO_WIDTH,
    parameter int ID_WIDTH   = $clog2(IRQ_NUM)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [IRQ_NUM-1:0]            ip_i,
    input  logic [IRQ_NUM-1:0]            ie_i,
    input  logic [IRQ_NUM*PRIO_WIDTH-1:0] prio_i,
    input  logic [PRIO_WIDTH-1:0]         thold_i,
    input  logic                          claim_req_i,
    output logic                          claim_ack_o,
    output logic [ID_WIDTH-1:0]           claim_id_o,
    output logic [IRQ_NUM-1:0]            claim_clr_o,
    output logic [ID_WIDTH-1:0]           max_id_o,
    output logic [PRIO_WIDTH-1:0]         max_prio_o,
    output logic                          irq_o,
    output logic                          sweep_done_o
);

    import plic_pkg::*;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   idx_q, best_id_q, max_id_q, claim_id_q, new_id;
    logic [PRIO_WIDTH-1:0] best_prio_q, max_prio_q, new_prio, cand_prio;
    logic                  sweep_done_q, cand_valid, last_idx, claim_take, max_live;

    always_comb begin
        cand_prio = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (idx_q == ID_WIDTH'(i)) cand_prio = prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
        end
    end

    assign cand_valid = ip_i[idx_q] & ie_i[idx_q] & (cand_prio != '0);
    assign last_idx   = (idx_q == ID_WIDTH'(IRQ_NUM - 1));
    assign claim_take = (state_q == SCAN) && claim_req_i;
    // The claim only returns the latched winner if it is still pending and enabled.
    assign max_live   = (max_id_q != '0) && ip_i[max_id_q] && ie_i[max_id_q];

    plic_prio_cmp #(
        .ID_WIDTH   (ID_WIDTH),
        .PRIO_WIDTH (PRIO_WIDTH)
    ) u_cmp (
        .cand_valid (cand_valid),
        .cand_id    (idx_q),
        .cand_prio  (cand_prio),
        .best_id    (best_id_q),
        .best_prio  (best_prio_q),
        .new_id     (new_id),
        .new_prio   (new_prio)
    );

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) state_q <= SCAN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:    if (claim_req_i) state_d = CLAIM;
            CLAIM:   state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        claim_ack_o = (state_q == CLAIM);
        claim_id_o  = claim_ack_o ? claim_id_q : '0;
        claim_clr_o = '0;
        if (claim_ack_o && (claim_id_q != '0)) claim_clr_o[claim_id_q] = 1'b1;
    end

    // Entering or sitting in CLAIM drops the in-flight sweep and the published
    // winner, so irq_o stays low until a complete fresh sweep lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q        <= ID_WIDTH'(1);
            best_id_q    <= '0;
            best_prio_q  <= '0;
            max_id_q     <= '0;
            max_prio_q   <= '0;
            claim_id_q   <= '0;
            sweep_done_q <= 1'b0;
        end else if (claim_take || (state_q == CLAIM)) begin
            if (claim_take) claim_id_q <= max_live ? max_id_q : '0;
            idx_q        <= ID_WIDTH'(1);
            best_id_q    <= '0;
            best_prio_q  <= '0;
            max_id_q     <= '0;
            max_prio_q   <= '0;
            sweep_done_q <= 1'b0;
        end else if (last_idx) begin
            max_id_q     <= new_id;
            max_prio_q   <= new_prio;
            best_id_q    <= '0;
            best_prio_q  <= '0;
            idx_q        <= ID_WIDTH'(1);
            sweep_done_q <= 1'b1;
        end else begin
            best_id_q    <= new_id;
            best_prio_q  <= new_prio;
            idx_q        <= idx_q + ID_WIDTH'(1);
            sweep_done_q <= 1'b0;
        end
    end

    assign max_id_o     = max_id_q;
    assign max_prio_o   = max_prio_q;
    assign irq_o        = (max_prio_q > thold_i);
    assign sweep_done_o = sweep_done_q;

endmodule

// File: tb/tb_plic_prio_scan.sv
// Directed bench for plic_prio_scan: table of steady-state sweep results plus
// hand-written claim race and reset sequences.
module tb_plic_prio_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ip, ie;
    logic [95:0] prio;
    logic [2:0]  thold;
    logic        claim_req;
    logic        claim_ack;
    logic [4:0]  claim_id;
    logic [31:0] claim_clr;
    logic [4:0]  max_id;
    logic [2:0]  max_prio;
    logic        irq;
    logic        sweep_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    plic_prio_scan dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ip_i         (ip),
        .ie_i         (ie),
        .prio_i       (prio),
        .thold_i      (thold),
        .claim_req_i  (claim_req),
        .claim_ack_o  (claim_ack),
        .claim_id_o   (claim_id),
        .claim_clr_o  (claim_clr),
        .max_id_o     (max_id),
        .max_prio_o   (max_prio),
        .irq_o        (irq),
        .sweep_done_o (sweep_done)
    );

    typedef struct {
        logic [31:0] ip;
        logic [31:0] ie;
        logic [95:0] prio;
        logic [2:0]  thold;
        logic [4:0]  exp_id;
        logic [2:0]  exp_prio;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] pr(input int a, input int pa, input int b, input int pb);
        logic [95:0] r;
        r = '0;
        r[a*3 +: 3] = 3'(pa);
        r[b*3 +: 3] = 3'(pb);
        return r;
    endfunction

    // Returns at the negedge where sweep_done is seen, with the cycle count.
    task automatic wait_sweep(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sweep_done && n < 40);
        check({tag, "_done_seen"}, 32'(sweep_done), 32'd1);
    endtask

    task automatic do_claim(input logic [4:0] eid, input string tag);
        claim_req = 1'b1;
        @(negedge clk);
        claim_req = 1'b0;
        check({tag, "_ack"}, 32'(claim_ack), 32'd1);
        check({tag, "_id"}, 32'(claim_id), 32'(eid));
        check({tag, "_clr"}, claim_clr, (eid != 5'd0) ? (32'd1 << eid) : 32'd0);
        @(negedge clk);
        check({tag, "_ack_gone"}, 32'(claim_ack), 32'd0);
        check({tag, "_irq_low"}, 32'(irq), 32'd0);
    endtask

    task automatic apply(input vec_t v);
        ip    = v.ip;
        ie    = v.ie;
        prio  = v.prio;
        thold = v.thold;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{32'h0, 32'h0, '0, 3'd0, 5'd0, 3'd0, 1'b0};
        vecs[1] = '{32'h88, 32'h88, pr(3, 2, 7, 5), 3'd1, 5'd7, 3'd5, 1'b1};
        vecs[2] = '{32'h210, 32'h210, pr(4, 3, 9, 3), 3'd3, 5'd4, 3'd3, 1'b0};
        vecs[3] = '{32'h210, 32'h210, pr(4, 3, 9, 3), 3'd2, 5'd4, 3'd3, 1'b1};
        vecs[4] = '{32'h60, 32'h40, pr(5, 4, 6, 0), 3'd0, 5'd0, 3'd0, 1'b0};
        vecs[5] = '{32'h60, 32'h60, pr(5, 4, 6, 0), 3'd0, 5'd5, 3'd4, 1'b1};
        vecs[6] = '{32'h8000_0004, 32'h8000_0004, pr(31, 7, 2, 6), 3'd7, 5'd31, 3'd7, 1'b0};
        vecs[7] = '{32'h8000_0002, 32'h8000_0002, pr(1, 1, 31, 1), 3'd0, 5'd1, 3'd1, 1'b1};
        vecs[8] = '{32'h5, 32'h5, pr(0, 7, 2, 3), 3'd2, 5'd2, 3'd3, 1'b1};
        vecs[9] = '{32'h400, 32'hFFFF_FFFF, pr(10, 6, 12, 6), 3'd5, 5'd10, 3'd6, 1'b1};

        rst = 1'b1; ip = '0; ie = '0; prio = '0; thold = '0; claim_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(claim_ack), 32'd0);
        check("rst_claim_id", 32'(claim_id), 32'd0);
        check("rst_clr", claim_clr, 32'd0);
        check("rst_max_id", 32'(max_id), 32'd0);
        check("rst_max_prio", 32'(max_prio), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_done", 32'(sweep_done), 32'd0);
        rst = 1'b0;

        wait_sweep("first", n);
        check("first_latency", 32'(n), 32'd31);
        check("empty_max_id", 32'(max_id), 32'd0);
        check("empty_irq", 32'(irq), 32'd0);
        do_claim(5'd0, "empty_claim");

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i]);
            wait_sweep($sformatf("v%0d_a", i), n);
            wait_sweep($sformatf("v%0d_b", i), n);
            check($sformatf("v%0d_max_id", i), 32'(max_id), 32'(vecs[i].exp_id));
            check($sformatf("v%0d_max_prio", i), 32'(max_prio), 32'(vecs[i].exp_prio));
            check($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
        end

        // Normal claim of source 7, then the rescan finds it again.
        apply(vecs[1]);
        wait_sweep("clm_a", n);
        wait_sweep("clm_b", n);
        do_claim(5'd7, "claim7");
        wait_sweep("clm_rescan", n);
        check("clm_rescan_id", 32'(max_id), 32'd7);
        check("clm_rescan_irq", 32'(irq), 32'd1);

        // Pending of the winner drops before the claim: stale irq, claim returns 0.
        ip = 32'h08;
        check("drop_stale_id", 32'(max_id), 32'd7);
        check("drop_stale_irq", 32'(irq), 32'd1);
        do_claim(5'd0, "drop_claim");

        // Claim in the final sweep cycle, request held into CLAIM.
        apply(vecs[1]);
        wait_sweep("fin_a", n);
        wait_sweep("fin_b", n);
        prio = pr(3, 2, 7, 1);
        repeat (30) @(negedge clk);
        check("fin_pre_done", 32'(sweep_done), 32'd0);
        claim_req = 1'b1;
        @(negedge clk);
        check("fin_ack", 32'(claim_ack), 32'd1);
        check("fin_id", 32'(claim_id), 32'd7);
        check("fin_clr", claim_clr, 32'h80);
        check("fin_no_done", 32'(sweep_done), 32'd0);
        @(negedge clk);
        claim_req = 1'b0;
        check("fin_second_req_no_ack", 32'(claim_ack), 32'd0);
        check("fin_max_cleared", 32'(max_id), 32'd0);
        check("fin_irq_low", 32'(irq), 32'd0);
        wait_sweep("fin_rescan", n);
        check("fin_rescan_latency", 32'(n), 32'd31);
        check("fin_rescan_id", 32'(max_id), 32'd3);
        check("fin_rescan_prio", 32'(max_prio), 32'd2);

        // Reset asserted during the CLAIM cycle.
        apply(vecs[1]);
        wait_sweep("rc_a", n);
        wait_sweep("rc_b", n);
        claim_req = 1'b1;
        @(negedge clk);
        claim_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rc_ack", 32'(claim_ack), 32'd0);
        check("rc_id", 32'(claim_id), 32'd0);
        check("rc_clr", claim_clr, 32'd0);
        check("rc_max_id", 32'(max_id), 32'd0);
        check("rc_max_prio", 32'(max_prio), 32'd0);
        check("rc_irq", 32'(irq), 32'd0);
        check("rc_done", 32'(sweep_done), 32'd0);
        rst = 1'b0;
        wait_sweep("rc_sweep", n);
        check("rc_latency", 32'(n), 32'd31);
        check("rc_max_after", 32'(max_id), 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plic_prio_scan.md
# plic_prio_scan

Serial priority scheduler for the PLIC target context. It scans interrupt sources 1..IRQ_NUM-1, one source per clock, and finds the highest-priority source that is both pending and enabled. It publishes that source's ID and priority, and drives the external interrupt line against the threshold. It also sequences the claim handshake: it returns the winning ID and issues a one-hot clear to the pending register. The block sits between the PLIC register file (IP/IE/priority/threshold) and the claim/complete register logic.

## Interface
- IRQ_NUM, 32, number of source slots including reserved ID 0
- PRIO_WIDTH, 3, priority field width; priority 0 means never interrupt
- ID_WIDTH, $clog2(IRQ_NUM), source ID width
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous and active-high
- ip_i  in  IRQ_NUM  pending bits from gateways; bit 0 ignored
- ie_i  in  IRQ_NUM  enable bits; bit 0 ignored
- prio_i  in  IRQ_NUM*PRIO_WIDTH  flattened priorities; source i at [i*PRIO_WIDTH +: PRIO_WIDTH]
- thold_i  in  PRIO_WIDTH  context threshold
- claim_req_i  in  1  single-cycle claim request (APB read of claim register)
- claim_ack_o  out  1  claim response valid, one-cycle pulse
- claim_id_o  out  ID_WIDTH  claimed ID; 0 = nothing to claim
- claim_clr_o  out  IRQ_NUM  one-hot pending-clear pulse, coincident with claim_ack_o
- max_id_o  out  ID_WIDTH  ID latched by the last completed sweep
- max_prio_o  out  PRIO_WIDTH  priority of max_id_o
- irq_o  out  1  max_prio_o > thold_i
- sweep_done_o  out  1  pulse when a sweep result is latched

## Operation
- The FSM has two states, SCAN and CLAIM. Reset state is SCAN.
- SCAN behaviour:
  - The index idx_q steps 1..IRQ_NUM-1, one per cycle.
  - Source idx_q is a candidate when ip_i[idx]&ie_i[idx]&(prio!=0).
  - A candidate replaces the running best (best_id_q, best_prio_q) only if prio > best_prio_q (strict). Ties therefore go to the lowest ID.
- End of sweep (the cycle evaluating idx_q==IRQ_NUM-1):
  - The final comparison result goes into max_id_q/max_prio_q.
  - sweep_done_o pulses, best is cleared to 0/0, and idx_q wraps to 1.
- If no candidate is found, the latched result is 0/0.
- Claim, with claim_req_i sampled in SCAN:
  - Next cycle the FSM enters CLAIM, asserts claim_ack_o, and drives claim_id_o = max_id_q if ip_i[max_id_q]&ie_i[max_id_q] (both sampled in the request cycle); otherwise it drives 0.
  - claim_clr_o = 1<<claim_id_o when claim_id_o != 0; otherwise 0.
  - In the CLAIM cycle max_id_q/max_prio_q are cleared to 0, best is cleared, and idx_q is set to 1. The next cycle is SCAN, starting a fresh sweep.
- claim_req_i asserted in CLAIM is ignored, with no ack.
- irq_o is combinational from max_prio_q and thold_i. With thold_i = 2^PRIO_WIDTH-1, irq_o is always 0.
- Width rules:
  - Priority comparisons are unsigned PRIO_WIDTH.
  - idx_q is ID_WIDTH and never takes value 0 or values >= IRQ_NUM.

## Timing
- Reset values: claim_ack_o=0, claim_id_o=0, claim_clr_o=0, max_id_o=0, max_prio_o=0, irq_o=0, sweep_done_o=0, idx_q=1, best=0/0.
- Sweep latency: IRQ_NUM-1 cycles. The first result appears IRQ_NUM-1 cycles after reset deassertion, and once per IRQ_NUM-1 cycles after that while no claim occurs.
- Worst case from a pending change to its reflection in max_id_o: 2*(IRQ_NUM-1) cycles.
- Claim latency: ack 1 cycle after the request. After a claim, irq_o is low until the next sweep completes, IRQ_NUM-1 cycles after the CLAIM cycle.
- Claim in the final sweep cycle: the claim uses the old max_id_q. The sweep result of that cycle is discarded, sweep_done_o does not pulse, and a rescan follows.
- Pending drop mid-sweep: per-cycle sampling applies. A stale max_id_q may keep irq_o high until the next sweep; the claim check returns 0 in that case.
- rst_i mid-sweep or in CLAIM: all state returns to reset values on the next edge. An in-flight claim ack is suppressed.

## Structure
- Shared package plic_pkg: IRQ_NUM, PRIO_WIDTH, ID_WIDTH defaults, and the state enum {SCAN, CLAIM}.
- Registers use the codebase dff primitives with synchronous active-high reset.
- No sub-module is needed. The per-cycle compare is small; optionally factor it as plic_prio_cmp (candidate/best in, new best out).

## Test plan
- Reset, no pending: after 31 cycles sweep_done_o pulses, max_id_o=0, irq_o=0. A claim returns ack with id 0 and claim_clr_o=0.
- Sources 3 (prio 2) and 7 (prio 5) pending+enabled, thold=1: after the sweep max_id_o=7, max_prio_o=5, irq_o=1. Claim gives ack id 7, claim_clr_o=0x80, and irq_o drops.
- Tie: sources 4 and 9 both prio 3 -> max_id_o=4. With thold=3 -> irq_o=0. With thold=2 -> irq_o=1.
- Disabled/zero-prio: source 5 pending with ie=0, source 6 pending with prio 0 -> max_id_o=0. Setting ie[5] with prio 4 -> max_id_o=5 within 62 cycles.
- Claim races:
  - Claim in the final sweep cycle returns the previous max and discards the sweep.
  - ip of max_id dropped before the claim -> ack id 0, no clear.
  - A second claim_req in the CLAIM cycle gets no ack.
- rst_i asserted for one cycle in CLAIM -> no ack, all outputs 0, and a full sweep restarts at idx 1.
